// File: rtl/if_id_queue_pkg.sv
// Shared pipeline definitions for the IF/ID and ID/EX registers.
// Also holds the occupancy classification that the queue uses for its handshake.
package if_id_queue_pkg;

  localparam int IF_ID_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [IF_ID_WIDTH-1:0] ir;
    logic [IF_ID_WIDTH-1:0] npc;
  } if_id_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;

  function automatic occ_state_t occ_state(input int unsigned occ, input int unsigned depth);
    occ_state_t s;
    if (occ == 0) s = OCC_EMPTY;
    else if (occ >= depth) s = OCC_FULL;
    else s = OCC_PARTIAL;
    return s;
  endfunction

endpackage

// File: rtl/if_id_fifo_mem.sv
// Entry storage for the IF/ID queue: one write port, one asynchronous read port.
// Deliberately unreset; the owner's occupancy count decides which entries are live.
module if_id_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int DW    = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID pipeline register fronted by a small circular queue so fetch can run ahead of a stalled decode.
// A taken branch from EX/MEM drops everything buffered plus anything offered in the same cycle.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = IF_ID_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_ir,
  input  logic [WIDTH-1:0]       in_npc,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_ir,
  output logic [WIDTH-1:0]       out_npc,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   OCC_ONE = 1;

  logic [PTR_W-1:0]   rd;
  logic [PTR_W-1:0]   wr;
  logic [PTR_W:0]     occ;
  occ_state_t         state;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;

  // Handshake derives from registered occupancy only, so in_ready never waits on decode.
  assign state     = occ_state(32'(occ), DEPTH);
  assign in_ready  = (state != OCC_FULL);
  assign out_valid = (state != OCC_EMPTY);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd  <= '0;
      wr  <= '0;
      occ <= '0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= '0;
      occ <= '0;
    end else begin
      if (push) wr <= wr + PTR_ONE;
      if (pop)  rd <= rd + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr),
    .wdata ({in_ir, in_npc}),
    .raddr (rd),
    .rdata (head)
  );

  // Stale storage stays hidden behind NOP/0 whenever nothing is live.
  assign out_ir  = out_valid ? head[2*WIDTH-1:WIDTH] : WIDTH'(NOP_INSTR);
  assign out_npc = out_valid ? head[WIDTH-1:0] : '0;
  assign count   = occ;

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue: a queue-based reference model with a negedge monitor.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_ir = '0;
  logic [WIDTH-1:0] in_npc = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_ir;
  logic [WIDTH-1:0] out_npc;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic [$clog2(DEPTH):0] count;

  if_id_t sb[$];
  int     popped = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ir     (in_ir),
    .in_npc    (in_npc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ir    (out_ir),
    .out_npc   (out_npc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a FIFO of accepted entries, capacity DEPTH, emptied by flush or reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      popped = 0;
    end else begin
      if (flush) sb.delete();
      else if (in_valid && (sb.size() + popped) < DEPTH)
        sb.push_back('{ir: in_ir, npc: in_npc});
      popped = 0;
    end
  end

  // Monitor: checks the visible state mid-cycle and retires the head whenever decode takes it.
  always @(negedge clk) begin
    compare("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
    compare("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    compare("count", 32'(count), sb.size());
    if (sb.size() == 0) begin
      compare("out_ir_nop", out_ir, NOP_INSTR);
      compare("out_npc_zero", out_npc, 32'h0);
    end else if (rst_n && out_ready && !flush) begin
      compare("pop_ir", out_ir, sb[0].ir);
      compare("pop_npc", out_npc, sb[0].npc);
      void'(sb.pop_front());
      popped = 1;
    end else begin
      compare("head_ir", out_ir, sb[0].ir);
      compare("head_npc", out_npc, sb[0].npc);
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [31:0] npc,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_ir     = ir;
    in_npc    = npc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_valid, input logic [31:0] exp_ir,
                             input logic exp_ready, input int exp_count);
    compare({name, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    compare({name, ".out_ir"}, out_ir, exp_ir);
    compare({name, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    compare({name, ".count"}, 32'(count), exp_count);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", 1'b0, 32'h0, 1'b1, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("reset_release", 1'b0, 32'h0, 1'b1, 0);

    applyStimulus(1'b1, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
    checkOutput("stream_first", 1'b1, 32'h2008_0005, 1'b1, 1);
    applyStimulus(1'b1, 32'h2129_0001, 32'h8, 1'b1, 1'b0);
    checkOutput("stream_second", 1'b1, 32'h2129_0001, 1'b1, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream_drain", 1'b0, 32'h0, 1'b1, 0);

    applyStimulus(1'b1, 32'hAAAA_0001, 32'h10, 1'b0, 1'b0);
    checkOutput("stall_a", 1'b1, 32'hAAAA_0001, 1'b1, 1);
    applyStimulus(1'b1, 32'hBBBB_0002, 32'h14, 1'b0, 1'b0);
    checkOutput("stall_b", 1'b1, 32'hAAAA_0001, 1'b0, 2);
    applyStimulus(1'b1, 32'hCCCC_0003, 32'h18, 1'b0, 1'b0);
    checkOutput("stall_c_held", 1'b1, 32'hAAAA_0001, 1'b0, 2);
    applyStimulus(1'b1, 32'hCCCC_0003, 32'h18, 1'b1, 1'b0);
    checkOutput("stall_pop_a", 1'b1, 32'hBBBB_0002, 1'b1, 1);
    applyStimulus(1'b1, 32'hCCCC_0003, 32'h18, 1'b1, 1'b0);
    checkOutput("stall_pop_b", 1'b1, 32'hCCCC_0003, 1'b1, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("stall_pop_c", 1'b0, 32'h0, 1'b1, 0);

    applyStimulus(1'b1, 32'h1111_0001, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1111_0002, 32'h24, 1'b0, 1'b0);
    checkOutput("flush_loaded", 1'b1, 32'h1111_0001, 1'b0, 2);
    applyStimulus(1'b1, 32'h0800_0010, 32'h28, 1'b1, 1'b1);
    checkOutput("flush_cleared", 1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_no_ghost", 1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b1, 32'h1111_0003, 32'h40, 1'b1, 1'b0);
    checkOutput("flush_refill", 1'b1, 32'h1111_0003, 1'b1, 1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h5000_0000 + i, 32'h100 + 4 * i, 1'b1, 1'b0);
      checkOutput($sformatf("wrap_push%0d", i), 1'b1, 32'h5000_0000 + i, 1'b1, 1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput($sformatf("wrap_stall%0d", i), 1'b1, 32'h5000_0000 + i, 1'b1, 1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h7777_0001, 32'h200, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7777_0002, 32'h204, 1'b0, 1'b0);
    checkOutput("areset_full", 1'b1, 32'h7777_0001, 1'b0, 2);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 checkOutput("areset_low", 1'b0, 32'h0, 1'b1, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("areset_after", 1'b0, 32'h0, 1'b1, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, $urandom, $urandom,
                    $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
    end
    repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("final_drain", 1'b0, 32'h0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decode-side receiver for the fetch stage: accepts fetched instruction/next-PC pairs over a valid/ready handshake and presents them to decode as the IF/ID pipeline register. A small FIFO absorbs decode stalls so fetch can run one or more instructions ahead. The queue discards all buffered and incoming entries on a taken branch from EX/MEM. It sits between the fetch stage and the decode stage; its `out_*` port is the IF/ID register that decode reads.

## Interface
- `DEPTH`, default 2: queue entries, ≥2, power of two.
- `WIDTH`, default 32: instruction and PC width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ir`  in  WIDTH  fetched instruction word.
- `in_npc`  in  WIDTH  PC+4 of that instruction.
- `in_ready`  out  1  queue accepts this cycle.
- `out_valid`  out  1  IF/ID register holds a live instruction.
- `out_ir`  out  WIDTH  instruction to decode; NOP (0x00000000) when `out_valid`=0.
- `out_npc`  out  WIDTH  NPC to decode; 0 when `out_valid`=0.
- `out_ready`  in  1  decode consumes (deasserted by the hazard unit on a stall).
- `flush`  in  1  taken branch or jump resolved in EX/MEM.
- `count`  out  log2(DEPTH)+1  current occupancy.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready` = (`count` < `DEPTH`). It is combinational from registered state only and never depends on `out_ready`: there is no full-queue pass-through.
- The head entry drives `out_ir`/`out_npc` directly from storage. `out_valid` = (`count` ≠ 0).
- Storage is circular, with read pointer `rd`, write pointer `wr`, and `count`. Pointers wrap modulo `DEPTH`.
- On simultaneous push and pop with 0 < `count` < `DEPTH`, `count` is unchanged and both pointers advance.
- Flush has priority over everything. When `flush`=1, on the next edge `count`←0 and `rd`←`wr`←0. A push or pop presented in the same cycle is dropped. Storage contents need not be cleared; the outputs are masked to NOP/0.
- Flush with `count`=0 is a no-op apart from the pointer reset.
- `in_valid` while `in_ready`=0 is ignored. Fetch must hold its PC; no error is flagged.
- There is no FSM beyond the occupancy counter. The states are EMPTY (`count`=0), PARTIAL, and FULL (`count`=`DEPTH`).

## Timing
- Reset (async assert, sync release): `count`=0, `rd`=`wr`=0, `out_valid`=0, `out_ir`=0x00000000, `out_npc`=0, `in_ready`=1.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency is 1 cycle: an instruction pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N.
- Throughput is 1 instruction per cycle sustained when `out_ready`=1.
- `in_ready` falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from FULL.
- `flush` asserted in cycle N gives `out_valid`=0 after edge N. The first post-flush instruction can be accepted in cycle N+1 and appears after edge N+1.
- `count` arithmetic is unsigned. Its width is sized so that `DEPTH` is representable with no overflow.

## Structure
- Shared pipeline package holds these items:
  - the `NOP_INSTR` constant (32'h00000000)
  - the `WIDTH` default
  - an `if_id_t` packed struct {ir, npc}, which is also reused by the ID/EX register
- Storage is a natural sub-module, `if_id_fifo_mem`: a DEPTH×(2·WIDTH) register array with one write port and one async read port. It has no reset; validity is carried by `count`.
- The top level contains the pointers, `count`, flush priority, and output masking.

## Test plan
- Reset then idle: hold `rst_n`=0 → `out_valid`=0, `out_ir`=0, `in_ready`=1, `count`=0. Release reset with `in_valid`=0 → all outputs unchanged.
- Stream: push 0x20080005/npc 0x4, then 0x21290001/npc 0x8 on consecutive cycles with `out_ready`=1 → outputs appear in order, one cycle after each push, and `count` stays ≤1.
- Stall fill: `out_ready`=0, push three instructions A, B, C → A and B accepted, `in_ready`=0 in the third cycle, C held. Raise `out_ready` → A, B, then C are delivered in order with no loss.
- Flush under load: with `count`=2, assert `flush` together with `in_valid` for 0x08000010 → next cycle `count`=0, `out_ir`=0, and 0x08000010 is not delivered.
- Wrap-around: 5 push/pop cycles interleaved with 1-cycle stalls (`DEPTH`=2) → pointers wrap, order is preserved, and `count` never exceeds 2.
- Async reset with `count`=2: pulse `rst_n` low between edges → `out_valid` drops immediately, and no stale entry reappears after release.
